// File: rtl/bn_param_loader.sv
// Streams batch-norm parameter words into a 2*OUT_CHANNELS-deep BRAM: region A, then region B.
// Optional trailing checksum word is enabled with `define BN_LOADER_CHECKSUM_EN.
module bn_param_loader #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned OUT_CHANNELS = 64,
    localparam int unsigned ADDR_WIDTH  = $clog2(2 * OUT_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  load_done,
    output logic                  checksum_err
);

    localparam logic [ADDR_WIDTH-1:0] LastA = ADDR_WIDTH'(OUT_CHANNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] LastB = ADDR_WIDTH'(2 * OUT_CHANNELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
`ifdef BN_LOADER_CHECKSUM_EN
        StCheck,
`endif
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    accept;
    logic                    xfer;

`ifdef BN_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    err_q, err_d;
`endif

    // Ready depends on state only, never on s_valid.
    always_comb begin
        accept = 1'b0;
        unique case (state_q)
            StLoadA, StLoadB: accept = 1'b1;
`ifdef BN_LOADER_CHECKSUM_EN
            StCheck:          accept = 1'b1;
`endif
            default:          accept = 1'b0;
        endcase
    end

    assign xfer = s_valid && accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef BN_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoadA;
                    cnt_d   = '0;
`ifdef BN_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end

            StLoadA: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = s_data;
                    cnt_d     = cnt_q + 1'b1;
`ifdef BN_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + s_data;
`endif
                    if (cnt_q == LastA) begin
                        state_d = StLoadB;
                    end
                end
            end

            StLoadB: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = s_data;
`ifdef BN_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + s_data;
`endif
                    // Counter parks on the last address rather than wrapping.
                    if (cnt_q == LastB) begin
`ifdef BN_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDone;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

`ifdef BN_LOADER_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    state_d = StDone;
                    err_d   = (s_data != sum_q);
                end
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef BN_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef BN_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

    assign s_ready   = accept;
    assign busy      = accept;
    assign load_done = (state_q == StDone);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

`ifdef BN_LOADER_CHECKSUM_EN
    assign checksum_err = err_q;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: doc/bn_param_loader.md
# bn_param_loader

Streaming writer that fills a batch-norm parameter BRAM at run time. It accepts parameter words on a valid/ready stream and emits a registered single-port write stream (enable, address, data) into a `2*OUT_CHANNELS`-deep memory:
- Region A, addresses `0..OUT_CHANNELS-1`: mean or gamma.
- Region B, addresses `OUT_CHANNELS..2*OUT_CHANNELS-1`: std or beta.

It sits between the host/DMA parameter path and each conv stage's BN parameter memory. Those memories stream their contents out through wrap-around read pointers.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each parameter word.
- `OUT_CHANNELS`, 64: channels per region. Memory depth is `2*OUT_CHANNELS`.
- `ADDR_WIDTH` (localparam), `$clog2(2*OUT_CHANNELS)`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a load.
- `s_valid`  in  1  input word valid.
- `s_data`  in  `DATA_WIDTH`  input parameter word.
- `s_ready`  out  1  loader accepts a word this cycle.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  `ADDR_WIDTH`  memory write address.
- `wr_data`  out  `DATA_WIDTH`  memory write data.
- `busy`  out  1  load in progress.
- `load_done`  out  1  level; last load completed.
- `checksum_err`  out  1  checksum mismatch on last load. Tied 0 without the macro.

## Operation
States: `IDLE`, `LOAD_A`, `LOAD_B`, `CHECK` (macro only), `DONE`.
- **Handshake:** a transfer occurs on any posedge where `s_valid && s_ready`. `s_ready` is decoded from the state register only, with no path from `s_valid`. It is 1 in `LOAD_A`, `LOAD_B` and `CHECK`.
- **IDLE / DONE:** `start` moves the FSM to `LOAD_A` and clears the word counter, `load_done`, `checksum_err` and the running sum.
- **LOAD_A:** each transfer writes `s_data` to address `cnt` and increments `cnt`. The transfer at `cnt == OUT_CHANNELS-1` moves the FSM to `LOAD_B`.
- **LOAD_B:** each transfer writes to address `cnt` and increments it. The transfer at `cnt == 2*OUT_CHANNELS-1` moves the FSM to `DONE`, or to `CHECK` with the macro.
- **Counter:** `cnt` is `ADDR_WIDTH` bits and runs 0 to `2*OUT_CHANNELS-1` with no wrap inside a load.
- **Write port:** `wr_en`, `wr_addr` and `wr_data` are registered. They reflect the transfer of the previous cycle, and `wr_en` is low otherwise.
- **`start` outside IDLE/DONE:** ignored while in `LOAD_A`, `LOAD_B` or `CHECK`. A load cannot be aborted except by reset.
- **Status:** `busy` = state ∈ {`LOAD_A`, `LOAD_B`, `CHECK`}. `load_done` = (state == `DONE`).
- **Gaps:** `s_valid` gaps of any length stall the FSM with no side effects.

## Timing
- **Reset values:** all outputs 0, state `IDLE`, `cnt` 0.
- **Reset mid-load:** takes effect on the same edge. `wr_en` is 0 on the next cycle. The BRAM holds partial contents, and downstream must not use it until `load_done`.
- **Start latency:** `start` at edge T → `s_ready` = 1 and `busy` = 1 from T+1.
- **Write latency:** transfer at edge k → `wr_en` = 1 during cycle k+1, with that word's address and data.
- **Throughput:** one word per cycle sustained.
- **Completion (no macro):** final word at edge k → `s_ready` = 0 and `load_done` = 1 from k+1. The last write is also in k+1.

## Configuration
Macro `BN_LOADER_CHECKSUM_EN`.
- **Defined:**
  - The loader keeps a running sum of all `2*OUT_CHANNELS` data words, modulo `2^DATA_WIDTH`.
  - After `LOAD_B` it enters `CHECK` and accepts exactly one further word, the checksum. That word is not written to memory.
  - On that transfer the FSM moves to `DONE`, and `checksum_err` is set if the word differs from the sum. `load_done` rises regardless.
- **Undefined:** no `CHECK` state, no sum register, and `checksum_err` is constant 0.

## Test plan
All scenarios use `OUT_CHANNELS=4`, `DATA_WIDTH=16`.
- **Reset values:** reset, then idle 5 cycles → all outputs 0, and `s_valid`=1 is not accepted (`s_ready`=0).
- **Back-to-back load:** `start`, then 8 back-to-back words `0x0001..0x0008` → writes at addresses 0..7 with matching data, one per cycle, each 1 cycle after its transfer. `load_done`=1 the cycle after the 8th transfer.
- **Stalls and ignored start:**
  - `s_valid` toggled 1/0 every cycle → 8 writes, all addresses correct, no duplicates.
  - Extra `start` pulses mid-load are ignored.
- **Reset mid-load:** reset after 5 transfers → `busy`=0 next cycle. A fresh `start` rewrites from address 0.
- **Checksum (macro):**
  - Words `0x0001..0x0008` then `0x0024` → `load_done`=1, `checksum_err`=0, 8 writes only.
  - Same data then `0x0025` → `checksum_err`=1.
- **Restart clears status:** `start` while in `DONE` with `checksum_err`=1 → both status bits clear next cycle and a new load proceeds.
